// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss-handling controller that sits in front of the cache data and tag
// arrays. When a miss is pending it fetches the 8-word (16-byte) block that
// contains the miss address from a pipelined memory. It steers each returning
// word into the data array with a one-hot word enable and a write strobe, and
// it writes the tag together with the final word. fsm_busy stays high for the
// whole fill so the core stalls.
//
// Read issue and data receive use separate counters. Data can therefore
// return while reads are still being issued. The memory must return words in
// the order it received the requests.
//
// Optional feature (compile-time macro):
//   CACHE_FILL_CRITICAL_FIRST_EN
//     defined   : the fill starts at the critical word (miss_address[3:1]) and
//                 wraps mod 8, for both issue and write order.
//     undefined : words are fetched and written 0..7 in order.
//
// Ports:
//   clk                in   single clock, rising edge
//   rst                in   asynchronous reset, active low
//   miss_detected      in   level, a cache miss is pending
//   miss_address       in   byte address of the miss, sampled at fill start
//   memory_data        in   word returned by memory
//   memory_data_valid  in   memory_data is valid this cycle
//   fsm_busy           out  a fill is in progress
//   mem_read           out  read request to memory this cycle
//   memory_address     out  byte address of the current read request
//   data_out           out  word to write into the data array (= memory_data)
//   write_data_array   out  data array write strobe
//   word_enable        out  one-hot word select for the data array
//   write_tag_array    out  tag array write strobe, on the final word
//   fill_done          out  one-cycle pulse with the final word write
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] data_out,
    output logic              write_data_array,
    output logic [7:0]        word_enable,
    output logic              write_tag_array,
    output logic              fill_done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // The block base always has bits [3:0] clear, so only the upper bits are stored.
    logic [ADDR_W-5:0] r_base_hi;
    logic [2:0]        r_start;
    logic [3:0]        r_issue_cnt;
    logic [3:0]        r_recv_cnt;

    logic [2:0]        w_start_nxt;
    logic [2:0]        w_issue_off;
    logic [2:0]        w_recv_off;
    logic              w_unused_addr_bits;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    assign w_start_nxt        = miss_address[3:1];
    assign w_unused_addr_bits = miss_address[0];
`else
    assign w_start_nxt        = 3'd0;
    assign w_unused_addr_bits = ^miss_address[3:0];
`endif

    // The 3-bit sums wrap from 7 to 0, so the offset never carries into the base.
    assign w_issue_off = r_start + r_issue_cnt[2:0];
    assign w_recv_off  = r_start + r_recv_cnt[2:0];

    assign fsm_busy = (r_state == ST_FILL);
    assign data_out = memory_data;

    // ------------------------------------------------------------------
    // Next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        mem_read         = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        word_enable      = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (miss_detected) begin
                    w_state_nxt = ST_FILL;
                end
            end

            ST_FILL: begin
                if (r_issue_cnt < 4'd8) begin
                    mem_read       = 1'b1;
                    memory_address = {r_base_hi, w_issue_off, 1'b0};
                end

                if (memory_data_valid && (r_recv_cnt < 4'd8)) begin
                    write_data_array = 1'b1;
                    word_enable      = 8'b0000_0001 << w_recv_off;
                    if (r_recv_cnt == 4'd7) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and fill bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_base_hi   <= '0;
            r_start     <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ST_IDLE) begin
                if (miss_detected) begin
                    r_base_hi   <= miss_address[ADDR_W-1:4];
                    r_start     <= w_start_nxt;
                    r_issue_cnt <= '0;
                    r_recv_cnt  <= '0;
                end
            end else begin
                // Both counters stop at 8 because their strobes are gated by cnt < 8.
                if (mem_read) begin
                    r_issue_cnt <= r_issue_cnt + 4'd1;
                end
                if (write_data_array) begin
                    r_recv_cnt <= r_recv_cnt + 4'd1;
                end
            end
        end
    end

endmodule
